// File: rtl/ysyx_23060180_lsu_pkg.sv
// Shared size encodings, FSM state type and size helper for the load/store unit.
// Pure declarations: no logic, no latency.
package ysyx_23060180_pkg;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_BEAT0 = 3'd1,
      ST_WAIT0 = 3'd2,
      ST_BEAT1 = 3'd3,
      ST_WAIT1 = 3'd4,
      ST_RESP  = 3'd5
   } lsu_state_e;

   function automatic logic [3:0] size_bytes(input logic [1:0] size);
      return 4'd1 << size;
   endfunction

endpackage

// File: rtl/ysyx_23060180_lsu_if.sv
// Core-side and memory-side bundles of the load/store unit.
// Core side is valid/ready with an unthrottled response pulse; memory side is valid/ready plus rvalid ack.
interface ysyx_23060180_lsu_req_if #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic [ADDR_W-1:0] req_addr;
   logic [XLEN-1:0]   req_wdata;
   logic [4:0]        req_rd;
   logic              resp_valid;
   logic [4:0]        resp_rd;
   logic [XLEN-1:0]   resp_data;
   logic              resp_err;

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_rd,
      input  req_ready, resp_valid, resp_rd, resp_data, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_rd,
      output req_ready, resp_valid, resp_rd, resp_data, resp_err
   );
endinterface

interface ysyx_23060180_lsu_mem_if #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
);
   logic              mem_req_valid;
   logic              mem_req_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [XLEN-1:0]   mem_wdata;
   logic [XLEN/8-1:0] mem_wstrb;
   logic              mem_rvalid;
   logic [XLEN-1:0]   mem_rdata;

   modport master (
      output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
      input  mem_req_ready, mem_rvalid, mem_rdata
   );

   modport slave (
      input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
      output mem_req_ready, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/ysyx_23060180_lsu_align.sv
// Byte-lane alignment: store strobe/data shifting over two beats and load extraction/extension.
// Purely combinational, zero latency, no backpressure.
module ysyx_23060180_lsu_align
   import ysyx_23060180_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [$clog2(XLEN/8)-1:0] off_i,
   input  logic [1:0]                size_i,
   input  logic                      unsigned_i,
   input  logic [XLEN-1:0]           wdata_i,
   input  logic [XLEN-1:0]           beat0_i,
   input  logic [XLEN-1:0]           beat1_i,
   output logic [XLEN/8-1:0]         strb_lo_o,
   output logic [XLEN/8-1:0]         strb_hi_o,
   output logic [XLEN-1:0]           wdata_lo_o,
   output logic [XLEN-1:0]           wdata_hi_o,
   output logic [XLEN-1:0]           ldata_o
);
   localparam int NB = XLEN / 8;

   logic [2*NB-1:0]   mask;
   logic [2*NB-1:0]   strb_full;
   logic [2*XLEN-1:0] wfull;
   logic [2*XLEN-1:0] rfull;
   logic              sign;
   int                nbytes;

   always_comb begin
      nbytes = int'(size_bytes(size_i));
      mask   = '0;
      for (int i = 0; i < 2*NB; i++) begin
         mask[i] = (i < nbytes);
      end
      strb_full = mask << off_i;
      wfull     = {{XLEN{1'b0}}, wdata_i} << {off_i, 3'b000};
      rfull     = {beat1_i, beat0_i} >> {off_i, 3'b000};

      case (size_i)
         SZ_B:    sign = rfull[7];
         SZ_H:    sign = rfull[15];
         SZ_W:    sign = rfull[31];
         default: sign = rfull[63];
      endcase

      // Bits above the access width are filled with the sign (or zero for unsigned loads).
      ldata_o = '0;
      for (int i = 0; i < XLEN; i++) begin
         ldata_o[i] = (i < 8*nbytes) ? rfull[i] : (sign & ~unsigned_i);
      end
   end

   assign strb_lo_o  = strb_full[NB-1:0];
   assign strb_hi_o  = strb_full[2*NB-1:NB];
   assign wdata_lo_o = wfull[XLEN-1:0];
   assign wdata_hi_o = wfull[2*XLEN-1:XLEN];

endmodule

// File: rtl/ysyx_23060180_lsu.sv
// Load/store unit: one access in flight, split into two bus beats when it crosses a lane boundary.
// Latency T+3 aligned, T+5 split, T+1 error; mem stalls add cycles; req_ready only in IDLE, resp has no backpressure.
module ysyx_23060180_lsu
   import ysyx_23060180_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int ADDR_W         = 32,
   parameter bit MISALIGN_SPLIT = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst,
   ysyx_23060180_lsu_req_if.slave  core,
   ysyx_23060180_lsu_mem_if.master mem
);
   localparam int NB = XLEN / 8;
   localparam int OW = $clog2(NB);

   lsu_state_e        state_q, state_d;
   logic              we_q, we_d;
   logic [1:0]        size_q, size_d;
   logic              uns_q, uns_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [XLEN-1:0]   wdata_q, wdata_d;
   logic [4:0]        rd_q, rd_d;
   logic              cross_q, cross_d;
   logic              err_q, err_d;
   logic [XLEN-1:0]   beat0_q, beat0_d;
   logic [XLEN-1:0]   beat1_q, beat1_d;

   logic [OW-1:0]     off_in;
   logic              cross_in;
   logic              illegal_in;
   logic              reject_in;
   logic [ADDR_W-1:0] addr_al;
   logic              in_beat0, in_beat1, in_resp;
   logic [NB-1:0]     strb_lo, strb_hi;
   logic [XLEN-1:0]   wdata_lo, wdata_hi, ldata;

   assign off_in     = core.req_addr[OW-1:0];
   assign cross_in   = (5'(off_in) + 5'(size_bytes(core.req_size))) > 5'(NB);
   assign illegal_in = (core.req_size == SZ_D) && (XLEN != 64);
   assign reject_in  = illegal_in || (cross_in && !MISALIGN_SPLIT);

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      size_d  = size_q;
      uns_d   = uns_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rd_d    = rd_q;
      cross_d = cross_q;
      err_d   = err_q;
      beat0_d = beat0_q;
      beat1_d = beat1_q;
      case (state_q)
         ST_IDLE: begin
            if (core.req_valid) begin
               we_d    = core.req_we;
               size_d  = core.req_size;
               uns_d   = core.req_unsigned;
               addr_d  = core.req_addr;
               wdata_d = core.req_we ? core.req_wdata : '0;
               rd_d    = core.req_rd;
               cross_d = cross_in;
               err_d   = reject_in;
               beat0_d = '0;
               beat1_d = '0;
               state_d = reject_in ? ST_RESP : ST_BEAT0;
            end
         end
         ST_BEAT0: if (mem.mem_req_ready) state_d = ST_WAIT0;
         ST_WAIT0: begin
            if (mem.mem_rvalid) begin
               beat0_d = mem.mem_rdata;
               state_d = cross_q ? ST_BEAT1 : ST_RESP;
            end
         end
         ST_BEAT1: if (mem.mem_req_ready) state_d = ST_WAIT1;
         ST_WAIT1: begin
            if (mem.mem_rvalid) begin
               beat1_d = mem.mem_rdata;
               state_d = ST_RESP;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         we_q    <= 1'b0;
         size_q  <= '0;
         uns_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rd_q    <= '0;
         cross_q <= 1'b0;
         err_q   <= 1'b0;
         beat0_q <= '0;
         beat1_q <= '0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rd_q    <= rd_d;
         cross_q <= cross_d;
         err_q   <= err_d;
         beat0_q <= beat0_d;
         beat1_q <= beat1_d;
      end
   end

   // Beat1 only contributes to load data when the access actually crossed lanes.
   ysyx_23060180_lsu_align #(.XLEN(XLEN)) u_align (
      .off_i      (addr_q[OW-1:0]),
      .size_i     (size_q),
      .unsigned_i (uns_q),
      .wdata_i    (wdata_q),
      .beat0_i    (beat0_q),
      .beat1_i    (cross_q ? beat1_q : '0),
      .strb_lo_o  (strb_lo),
      .strb_hi_o  (strb_hi),
      .wdata_lo_o (wdata_lo),
      .wdata_hi_o (wdata_hi),
      .ldata_o    (ldata)
   );

   assign in_beat0 = (state_q == ST_BEAT0);
   assign in_beat1 = (state_q == ST_BEAT1);
   assign in_resp  = (state_q == ST_RESP);
   assign addr_al  = addr_q & {{(ADDR_W-OW){1'b1}}, {OW{1'b0}}};

   assign core.req_ready = (state_q == ST_IDLE);

   assign mem.mem_req_valid = in_beat0 | in_beat1;
   assign mem.mem_we        = (in_beat0 | in_beat1) & we_q;
   assign mem.mem_addr      = in_beat0 ? addr_al :
                              in_beat1 ? addr_al + ADDR_W'(NB) : '0;
   assign mem.mem_wdata     = in_beat0 ? wdata_lo :
                              in_beat1 ? wdata_hi : '0;
   assign mem.mem_wstrb     = (in_beat0 && we_q) ? strb_lo :
                              (in_beat1 && we_q) ? strb_hi : '0;

   assign core.resp_valid = in_resp;
   assign core.resp_rd    = in_resp ? rd_q : '0;
   assign core.resp_err   = in_resp & err_q;
   assign core.resp_data  = (in_resp && !we_q && !err_q) ? ldata : '0;

endmodule

// File: tb/tb_ysyx_23060180_lsu.sv
// Directed bench for the load/store unit: vector table plus stall and mid-access reset sequences.
module tb_ysyx_23060180_lsu;
   import ysyx_23060180_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Shared stimulus; sel=0 targets the split DUT, sel=1 the error-on-misalign DUT.
   logic        sel = 1'b0;
   logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
   logic [1:0]  req_size = 2'd0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic [4:0]  req_rd = '0;
   logic        mem_req_ready = 1'b0, mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;

   ysyx_23060180_lsu_req_if #(.XLEN(32), .ADDR_W(32)) rq_s ();
   ysyx_23060180_lsu_req_if #(.XLEN(32), .ADDR_W(32)) rq_e ();
   ysyx_23060180_lsu_mem_if #(.XLEN(32), .ADDR_W(32)) mm_s ();
   ysyx_23060180_lsu_mem_if #(.XLEN(32), .ADDR_W(32)) mm_e ();

   assign rq_s.req_valid    = req_valid & ~sel;
   assign rq_e.req_valid    = req_valid & sel;
   assign rq_s.req_we       = req_we;        assign rq_e.req_we       = req_we;
   assign rq_s.req_size     = req_size;      assign rq_e.req_size     = req_size;
   assign rq_s.req_unsigned = req_unsigned;  assign rq_e.req_unsigned = req_unsigned;
   assign rq_s.req_addr     = req_addr;      assign rq_e.req_addr     = req_addr;
   assign rq_s.req_wdata    = req_wdata;     assign rq_e.req_wdata    = req_wdata;
   assign rq_s.req_rd       = req_rd;        assign rq_e.req_rd       = req_rd;
   assign mm_s.mem_req_ready = mem_req_ready & ~sel;
   assign mm_e.mem_req_ready = mem_req_ready & sel;
   assign mm_s.mem_rvalid    = mem_rvalid & ~sel;
   assign mm_e.mem_rvalid    = mem_rvalid & sel;
   assign mm_s.mem_rdata     = mem_rdata;
   assign mm_e.mem_rdata     = mem_rdata;

   ysyx_23060180_lsu #(.XLEN(32), .ADDR_W(32), .MISALIGN_SPLIT(1'b1)) dut_s (
      .clk (clk), .rst (rst), .core (rq_s), .mem (mm_s)
   );
   ysyx_23060180_lsu #(.XLEN(32), .ADDR_W(32), .MISALIGN_SPLIT(1'b0)) dut_e (
      .clk (clk), .rst (rst), .core (rq_e), .mem (mm_e)
   );

   logic        o_req_ready, o_mrv, o_mwe, o_rv, o_err;
   logic [31:0] o_maddr, o_mwdata, o_rdata;
   logic [3:0]  o_wstrb;
   logic [4:0]  o_rd;
   assign o_req_ready = sel ? rq_e.req_ready     : rq_s.req_ready;
   assign o_mrv       = sel ? mm_e.mem_req_valid : mm_s.mem_req_valid;
   assign o_mwe       = sel ? mm_e.mem_we        : mm_s.mem_we;
   assign o_maddr     = sel ? mm_e.mem_addr      : mm_s.mem_addr;
   assign o_mwdata    = sel ? mm_e.mem_wdata     : mm_s.mem_wdata;
   assign o_wstrb     = sel ? mm_e.mem_wstrb     : mm_s.mem_wstrb;
   assign o_rv        = sel ? rq_e.resp_valid    : rq_s.resp_valid;
   assign o_rdata     = sel ? rq_e.resp_data     : rq_s.resp_data;
   assign o_err       = sel ? rq_e.resp_err      : rq_s.resp_err;
   assign o_rd        = sel ? rq_e.resp_rd       : rq_s.resp_rd;

   // Observations of the most recent access.
   int          lat, nbeats;
   logic [31:0] r_data;
   logic        r_err, unstable, rr_hi;
   logic [4:0]  r_rd;
   logic [31:0] b_addr [2];
   logic [31:0] b_wdata[2];
   logic [3:0]  b_strb [2];
   logic        b_we   [2];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Starts and ends on a falling edge with the DUT idle; plays the memory side with
   // rstall cycles of mem_req_ready low per beat and rdelay extra cycles before rvalid.
   task automatic run_access(input logic s, input logic we, input logic [1:0] sz, input logic un,
                             input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                             input logic [31:0] d0, input logic [31:0] d1,
                             input int rstall, input int rdelay);
      int  stall, wcnt, idx;
      bit  waiting, inbeat;
      sel = s; req_we = we; req_size = sz; req_unsigned = un;
      req_addr = a; req_wdata = wd; req_rd = rd; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      lat = -1; nbeats = 0; unstable = 1'b0; rr_hi = 1'b0;
      r_data = '0; r_err = 1'b0; r_rd = '0;
      stall = 0; wcnt = 0; waiting = 1'b0; inbeat = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
         if (o_rv) begin
            lat = n; r_data = o_rdata; r_err = o_err; r_rd = o_rd;
            break;
         end
         if (o_req_ready) rr_hi = 1'b1;
         if (waiting) begin
            if (wcnt == rdelay) begin
               mem_rvalid = 1'b1;
               mem_rdata  = (nbeats == 1) ? d0 : d1;
               waiting    = 1'b0;
            end else begin
               wcnt++;
            end
         end else if (o_mrv) begin
            idx = (nbeats < 2) ? nbeats : 1;
            if (!inbeat) begin
               b_addr[idx] = o_maddr; b_wdata[idx] = o_mwdata;
               b_strb[idx] = o_wstrb; b_we[idx] = o_mwe;
               inbeat = 1'b1;
            end else if (b_addr[idx] !== o_maddr || b_wdata[idx] !== o_mwdata ||
                         b_strb[idx] !== o_wstrb || b_we[idx] !== o_mwe) begin
               unstable = 1'b1;
            end
            if (stall == rstall) begin
               mem_req_ready = 1'b1;
               waiting = 1'b1; wcnt = 0; inbeat = 1'b0; stall = 0;
               nbeats++;
            end else begin
               stall++;
            end
         end
         @(negedge clk);
      end
      mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      @(negedge clk);
   endtask

   typedef struct {
      logic        s, we;
      logic [1:0]  sz;
      logic        un;
      logic [31:0] a, wd;
      logic [4:0]  rd;
      logic [31:0] d0, d1;
      int          lat;
      logic [31:0] data;
      logic        err;
      int          nb;
      logic [31:0] a0;
      logic [3:0]  s0;
      logic [31:0] w0, a1;
      logic [3:0]  s1;
      logic [31:0] w1;
   } vec_t;

   vec_t v[16];
   logic saw;

   initial begin
      // s we sz un addr wdata rd d0 d1 | lat data err nb a0 s0 w0 a1 s1 w1
      v[0]  = '{0,0,SZ_W,0,32'h80000004,32'h0,5'd1,32'hDEADBEEF,32'h0, 3,32'hDEADBEEF,0,1, 32'h80000004,4'h0,32'h0, 32'h0,4'h0,32'h0};
      v[1]  = '{0,0,SZ_B,0,32'h80000003,32'h0,5'd2,32'h80FFFFFF,32'h0, 3,32'hFFFFFF80,0,1, 32'h80000000,4'h0,32'h0, 32'h0,4'h0,32'h0};
      v[2]  = '{0,0,SZ_B,1,32'h80000003,32'h0,5'd3,32'h80FFFFFF,32'h0, 3,32'h00000080,0,1, 32'h80000000,4'h0,32'h0, 32'h0,4'h0,32'h0};
      v[3]  = '{0,1,SZ_H,0,32'h80000003,32'h0000ABCD,5'd4,32'h0,32'h0, 5,32'h0,0,2, 32'h80000000,4'h8,32'hCD000000, 32'h80000004,4'h1,32'h000000AB};
      v[4]  = '{1,1,SZ_H,0,32'h80000003,32'h0000ABCD,5'd5,32'h0,32'h0, 1,32'h0,1,0, 32'h0,4'h0,32'h0, 32'h0,4'h0,32'h0};
      v[5]  = '{0,0,SZ_D,0,32'h80000000,32'h0,5'd6,32'h0,32'h0, 1,32'h0,1,0, 32'h0,4'h0,32'h0, 32'h0,4'h0,32'h0};
      v[6]  = '{0,0,SZ_H,0,32'h80000002,32'h0,5'd7,32'h80011234,32'h0, 3,32'hFFFF8001,0,1, 32'h80000000,4'h0,32'h0, 32'h0,4'h0,32'h0};
      v[7]  = '{0,0,SZ_H,1,32'h80000002,32'h0,5'd8,32'h80011234,32'h0, 3,32'h00008001,0,1, 32'h80000000,4'h0,32'h0, 32'h0,4'h0,32'h0};
      v[8]  = '{0,0,SZ_W,0,32'h80000001,32'h0,5'd9,32'h44332211,32'h88776655, 5,32'h55443322,0,2, 32'h80000000,4'h0,32'h0, 32'h80000004,4'h0,32'h0};
      v[9]  = '{0,0,SZ_H,0,32'h80000003,32'h0,5'd10,32'h44332211,32'h887766F5, 5,32'hFFFFF544,0,2, 32'h80000000,4'h0,32'h0, 32'h80000004,4'h0,32'h0};
      v[10] = '{0,1,SZ_W,0,32'h80000008,32'h12345678,5'd11,32'h0,32'h0, 3,32'h0,0,1, 32'h80000008,4'hF,32'h12345678, 32'h0,4'h0,32'h0};
      v[11] = '{0,1,SZ_B,0,32'h80000006,32'h000000A5,5'd12,32'h0,32'h0, 3,32'h0,0,1, 32'h80000004,4'h4,32'h00A50000, 32'h0,4'h0,32'h0};
      v[12] = '{0,0,SZ_W,0,32'hFFFFFFFE,32'h0,5'd13,32'hBBAA1111,32'h2222DDCC, 5,32'hDDCCBBAA,0,2, 32'hFFFFFFFC,4'h0,32'h0, 32'h00000000,4'h0,32'h0};
      v[13] = '{1,0,SZ_W,0,32'h80000002,32'h0,5'd14,32'h0,32'h0, 1,32'h0,1,0, 32'h0,4'h0,32'h0, 32'h0,4'h0,32'h0};
      v[14] = '{1,0,SZ_H,0,32'h80000001,32'h0,5'd15,32'h00ABCD00,32'h0, 3,32'hFFFFABCD,0,1, 32'h80000000,4'h0,32'h0, 32'h0,4'h0,32'h0};
      v[15] = '{0,1,SZ_B,0,32'h80000007,32'hFFFFFF5A,5'd16,32'h0,32'h0, 3,32'h0,0,1, 32'h80000004,4'h8,32'h5A000000, 32'h0,4'h0,32'h0};

      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset req_ready s", 32'(rq_s.req_ready), 32'd1);
      chk("reset req_ready e", 32'(rq_e.req_ready), 32'd1);
      chk("reset mem_req_valid", 32'(mm_s.mem_req_valid | mm_e.mem_req_valid), 32'd0);
      chk("reset resp_valid", 32'(rq_s.resp_valid | rq_e.resp_valid), 32'd0);
      chk("reset mem_wstrb", 32'(mm_s.mem_wstrb), 32'd0);
      chk("reset resp_data", rq_s.resp_data, 32'd0);
      @(negedge clk);

      for (int i = 0; i < 16; i++) begin
         run_access(v[i].s, v[i].we, v[i].sz, v[i].un, v[i].a, v[i].wd, v[i].rd,
                    v[i].d0, v[i].d1, 0, 0);
         chk($sformatf("v%0d latency", i), 32'(lat), 32'(v[i].lat));
         chk($sformatf("v%0d resp_data", i), r_data, v[i].data);
         chk($sformatf("v%0d resp_err", i), 32'(r_err), 32'(v[i].err));
         chk($sformatf("v%0d resp_rd", i), 32'(r_rd), 32'(v[i].rd));
         chk($sformatf("v%0d beats", i), 32'(nbeats), 32'(v[i].nb));
         if (v[i].nb >= 1) begin
            chk($sformatf("v%0d beat0 addr", i), b_addr[0], v[i].a0);
            chk($sformatf("v%0d beat0 strb", i), 32'(b_strb[0]), 32'(v[i].s0));
            chk($sformatf("v%0d beat0 we", i), 32'(b_we[0]), 32'(v[i].we));
            if (v[i].we) chk($sformatf("v%0d beat0 wdata", i), b_wdata[0], v[i].w0);
         end
         if (v[i].nb == 2) begin
            chk($sformatf("v%0d beat1 addr", i), b_addr[1], v[i].a1);
            chk($sformatf("v%0d beat1 strb", i), 32'(b_strb[1]), 32'(v[i].s1));
            if (v[i].we) chk($sformatf("v%0d beat1 wdata", i), b_wdata[1], v[i].w1);
         end
      end

      // Request stalled three cycles, then rvalid two cycles late.
      run_access(0, 0, SZ_W, 0, 32'h80000004, 32'h0, 5'd17, 32'h0BADF00D, 32'h0, 3, 2);
      chk("stall latency", 32'(lat), 32'd8);
      chk("stall resp_data", r_data, 32'h0BADF00D);
      chk("stall mem outputs stable", 32'(unstable), 32'd0);
      chk("stall req_ready low in flight", 32'(rr_hi), 32'd0);
      chk("stall beat addr", b_addr[0], 32'h80000004);
      chk("stall req_ready after resp", 32'(o_req_ready), 32'd1);

      // Reset while waiting for read data; the late rvalid must be ignored.
      sel = 1'b0; req_we = 1'b0; req_size = SZ_W; req_unsigned = 1'b0;
      req_addr = 32'h80000004; req_rd = 5'd18; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      chk("rst beat issued", 32'(o_mrv), 32'd1);
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 32'h11111111;
      saw = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         mem_rvalid = 1'b0; mem_rdata = '0;
         if (o_rv) saw = 1'b1;
      end
      chk("rst no resp_valid", 32'(saw), 32'd0);
      chk("rst idle req_ready", 32'(o_req_ready), 32'd1);
      chk("rst no mem_req_valid", 32'(o_mrv), 32'd0);

      run_access(0, 0, SZ_W, 0, 32'h80000004, 32'h0, 5'd19, 32'hCAFEF00D, 32'h0, 0, 0);
      chk("post-rst latency", 32'(lat), 32'd3);
      chk("post-rst resp_data", r_data, 32'hCAFEF00D);
      chk("post-rst resp_rd", 32'(r_rd), 32'd19);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ysyx_23060180_lsu.md
# ysyx_23060180_lsu

Parametrised load/store unit that sits between the core's execute stage and the data memory port. It replaces the fixed one-cycle, lane-0-only memory path with a valid/ready request handshake and variable-latency memory responses. It also provides byte-lane alignment, write strobes, sign/zero extension, and optional splitting of misaligned accesses into two bus beats. One access is in flight at a time.

## Interface
Parameters:
- XLEN, 32 — data width, 32 or 64; bus width = XLEN, NB = XLEN/8 byte lanes
- ADDR_W, 32 — address width
- MISALIGN_SPLIT, 1 — 1: lane-crossing accesses use two beats; 0: flagged as error, no bus access

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  core access request
- req_ready  out  1  high only in IDLE
- req_we  in  1  1 store, 0 load
- req_size  in  2  0 byte, 1 half, 2 word, 3 dword (legal only for XLEN=64)
- req_unsigned  in  1  loads: zero-extend (lbu/lhu/lwu)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  XLEN  store data, LSB-justified
- req_rd  in  5  destination register tag, returned unchanged
- mem_req_valid  out  1  bus beat request
- mem_req_ready  in  1  bus accepts the beat
- mem_we  out  1  beat is a write
- mem_addr  out  ADDR_W  NB-aligned beat address
- mem_wdata  out  XLEN  lane-shifted store data
- mem_wstrb  out  NB  byte enables; all zero for reads
- mem_rvalid  in  1  beat completion; read data or write ack
- mem_rdata  in  XLEN  read data
- resp_valid  out  1  one-cycle completion pulse; no backpressure
- resp_rd  out  5  tag of completed access
- resp_data  out  XLEN  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned with MISALIGN_SPLIT=0, or illegal size

## Operation
- FSM states: IDLE, BEAT0, WAIT0, BEAT1, WAIT1, RESP.
- IDLE: on req_valid && req_ready, latch the request and compute off = addr mod NB, bytes = 1<<size, and cross = off+bytes > NB.
  - Illegal size, or cross with MISALIGN_SPLIT=0 → RESP with resp_err=1.
  - Otherwise → BEAT0.
- BEAT0: mem_req_valid=1, mem_addr = addr & ~(NB-1). Hold all mem_* outputs stable until mem_req_ready, then → WAIT0.
- WAIT0: on mem_rvalid, capture mem_rdata into beat0 register; → BEAT1 if cross, else RESP.
- BEAT1 / WAIT1: same as BEAT0/WAIT0 with mem_addr = aligned addr + NB; capture beat1; → RESP.
- RESP: assert resp_valid for one cycle; → IDLE.
- mem_rvalid is ignored outside WAIT0/WAIT1.
- Store strobes: full = ((1<<bytes)-1) << off, computed at 2*NB bits. Beat0 strobe = low NB bits; beat1 strobe = high NB bits. mem_wdata is the same split of ({XLEN'0, wdata} << 8*off).
- Load data: ({beat1, beat0} >> 8*off), truncated to 8*bytes bits, then sign-extended (req_unsigned=0) or zero-extended to XLEN. Only beat0 is used when not crossing.
- Writes still wait for mem_rvalid as an ack; resp_data=0.
- Wrap-around: the beat1 address wraps modulo 2^ADDR_W and is not flagged.

## Timing
- Reset values: req_ready=1 after release; all other outputs and state = 0; FSM = IDLE.
- rst asserted mid-access aborts immediately: no resp_valid, and any later mem_rvalid is ignored.
- Latency from acceptance edge T, with mem_req_ready high and rvalid one cycle after each handshake:
  - Aligned access: resp_valid at T+3.
  - Split access: resp_valid at T+5.
  - Error: resp_valid at T+1, no mem_req_valid.
- Each additional stall cycle on mem_req_ready or mem_rvalid adds one cycle of latency.
- mem_rvalid in the same cycle as a beat handshake is a protocol violation and is not captured.
- Back-to-back: the next request is accepted in the cycle after RESP, giving a minimum of 4 cycles per aligned access.

## Structure
- Shared package ysyx_23060180_pkg holds:
  - the size encoding constants (SZ_B/SZ_H/SZ_W/SZ_D)
  - the FSM state enum
  - a function returning bytes for a given size
- Sub-module ysyx_23060180_lsu_align (combinational) covers strobe/wdata lane shifting and load extraction/extension, parametrised by XLEN. The top level holds the FSM and request/beat registers.

## Test plan
- Aligned lw, XLEN=32, addr 0x80000004, mem_rdata 0xDEADBEEF, zero-wait memory → one beat at 0x80000004, resp_data 0xDEADBEEF at T+3.
- lb addr 0x80000003, rdata 0x80FFFFFF → resp_data 0xFFFFFF80. Same access as lbu → 0x00000080.
- sh addr 0x80000003, wdata 0x0000ABCD, SPLIT=1 → two beats:
  - beat0: addr 0x80000000, strb 0b1000, wdata[31:24]=0xCD
  - beat1: addr 0x80000004, strb 0b0001, wdata[7:0]=0xAB
  - resp at T+5
- Same sh with SPLIT=0 → no mem_req_valid, resp_err=1 at T+1. size=3 with XLEN=32 behaves the same.
- mem_req_ready low for 3 cycles, then rvalid delayed 2 cycles → mem_* outputs held stable throughout, resp_valid at T+8, req_ready low until RESP.
- rst pulsed in WAIT0, then a stale mem_rvalid arrives → no resp_valid, FSM in IDLE. A following aligned lw completes normally.
